// File: rtl/promedio_uart_tx.sv
// promedio_uart_tx: consumer end of the averager's result interface.
// Captures each averaged value on its one-cycle data_valid pulse and sends it
// as NB = ceil(N/8) UART bytes (8N1), most significant byte first.
// A one-deep shadow register holds a value that arrives mid-frame. A value
// arriving while the shadow is already full is dropped, and the sticky overrun
// flag is set.
// Optional build macro PROMEDIO_TX_HEADER_EN: when it is defined, every frame is
// prefixed with the sync byte 0xA5.
module promedio_uart_tx #(
   parameter int N       = 8,
   parameter int CLK_DIV = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] data_in,
   input  logic         data_valid,
   input  logic         ovr_clr,
   output logic         tx,
   output logic         busy,
   output logic         overrun
);

   localparam int NB = (N + 7) / 8;
   localparam int DW = NB * 8;
`ifdef PROMEDIO_TX_HEADER_EN
   localparam int NBYTES = NB + 1;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
   localparam int NBYTES = NB;
`endif
   localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE   = BCW'(NBYTES - 1);
   localparam logic [15:0]    BAUD_RELOAD = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q;
   logic             tx_q;
   logic             busy_q;
   logic             overrun_q;
   logic [DW-1:0]    txd_q;         // value being transmitted, zero-extended
   logic [N-1:0]     shadow_q;      // value waiting behind the current frame
   logic             shadow_full_q;
   logic [7:0]       sh_q;          // current byte, shifted out LSB first
   logic [15:0]      baud_q;        // cycles left in the current bit
   logic [2:0]       bit_cnt_q;
   logic [BCW-1:0]   byte_cnt_q;

   logic             baud_tick;
   logic             more_bytes;
   logic             frame_end;
   logic             take_direct;
   logic             ovr_event;
   logic [7:0]       cur_byte;

   // Zero-extend a captured value to a whole number of bytes.
   function automatic logic [DW-1:0] zext(input logic [N-1:0] v);
      logic [DW-1:0] r;
      r        = '0;
      r[N-1:0] = v;
      return r;
   endfunction

   // Pick the byte with index k of the frame, counting from the first byte on the line.
   function automatic logic [7:0] byte_sel(input logic [DW-1:0] d,
                                           input logic [BCW-1:0] k);
      logic [7:0] r;
      r = 8'h00;
`ifdef PROMEDIO_TX_HEADER_EN
      if (k == '0) r = SYNC_BYTE;
      for (int i = 0; i < NB; i++) begin
         if (k == BCW'(i + 1)) r = d[(NB-1-i)*8 +: 8];
      end
`else
      for (int i = 0; i < NB; i++) begin
         if (k == BCW'(i)) r = d[(NB-1-i)*8 +: 8];
      end
`endif
      return r;
   endfunction

   // Bit-boundary, end-of-frame and buffering decisions shared by the FSM.
   always_comb begin
      baud_tick   = 1'b0;
      more_bytes  = 1'b0;
      frame_end   = 1'b0;
      take_direct = 1'b0;
      ovr_event   = 1'b0;
      cur_byte    = byte_sel(txd_q, byte_cnt_q);
      baud_tick   = (baud_q == 16'd0);
      more_bytes  = (byte_cnt_q != LAST_BYTE);
      frame_end   = (state_q == STOP) && baud_tick && !more_bytes;
      // A value arriving exactly as the last stop bit ends, with nothing
      // pending, becomes the next frame without passing through the shadow.
      take_direct = frame_end && !shadow_full_q && data_valid;
      ovr_event   = (state_q != IDLE) && data_valid && shadow_full_q && !frame_end;
   end

   // Transmit FSM, shadow buffer and overrun flag, with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         tx_q          <= 1'b1;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         txd_q         <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         sh_q          <= 8'h00;
         baud_q        <= 16'd0;
         bit_cnt_q     <= 3'd0;
         byte_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_valid) begin
                  txd_q      <= zext(data_in);
                  byte_cnt_q <= '0;
                  baud_q     <= BAUD_RELOAD;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= START;
               end
            end

            START: begin
               if (baud_tick) begin
                  sh_q      <= cur_byte;
                  tx_q      <= cur_byte[0];
                  bit_cnt_q <= 3'd0;
                  baud_q    <= BAUD_RELOAD;
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

            DATA: begin
               if (baud_tick) begin
                  baud_q <= BAUD_RELOAD;
                  if (bit_cnt_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     sh_q      <= {1'b0, sh_q[7:1]};
                     tx_q      <= sh_q[1];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

            STOP: begin
               if (baud_tick) begin
                  if (more_bytes) begin
                     byte_cnt_q <= byte_cnt_q + BCW'(1);
                     baud_q     <= BAUD_RELOAD;
                     tx_q       <= 1'b0;
                     state_q    <= START;
                  end else if (shadow_full_q) begin
                     txd_q      <= zext(shadow_q);
                     byte_cnt_q <= '0;
                     baud_q     <= BAUD_RELOAD;
                     tx_q       <= 1'b0;
                     state_q    <= START;
                  end else if (take_direct) begin
                     txd_q      <= zext(data_in);
                     byte_cnt_q <= '0;
                     baud_q     <= BAUD_RELOAD;
                     tx_q       <= 1'b0;
                     state_q    <= START;
                  end else begin
                     byte_cnt_q <= '0;
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase

         // Shadow: filled by mid-frame arrivals, drained at the end of a frame.
         if (state_q != IDLE) begin
            if (frame_end && shadow_full_q) begin
               if (data_valid) begin
                  shadow_q <= data_in;
               end else begin
                  shadow_full_q <= 1'b0;
               end
            end else if (data_valid && !frame_end && !shadow_full_q) begin
               shadow_q      <= data_in;
               shadow_full_q <= 1'b1;
            end
         end

         // A new drop beats a simultaneous clear.
         if (ovr_event) begin
            overrun_q <= 1'b1;
         end else if (ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_promedio_uart_tx.sv
// Bench for promedio_uart_tx: three instances, with N/CLK_DIV set to 8/4, 16/4 and 12/2.
// The stimulus pushes the expected UART bytes into per-instance queues. Monitors
// decode each tx line and compare every byte they receive against its queue.
module tb_promedio_uart_tx;

`ifdef PROMEDIO_TX_HEADER_EN
   localparam int HB = 1;
`else
   localparam int HB = 0;
`endif

   logic        clk;
   logic        reset;
   logic [7:0]  d8;
   logic        dv8, clr8, tx8, busy8, ovr8;
   logic [15:0] d16;
   logic        dv16, clr16, tx16, busy16, ovr16;
   logic [11:0] d12;
   logic        dv12, clr12, tx12, busy12, ovr12;

   int checks = 0;
   int errors = 0;

   logic [7:0] expq [3][$];
   logic       abort_f [3];
   int         run_len [3];
   int         last_run [3];
   int         done_cnt [3];

   promedio_uart_tx #(.N(8), .CLK_DIV(4)) u8 (
      .clk(clk), .reset(reset), .data_in(d8), .data_valid(dv8), .ovr_clr(clr8),
      .tx(tx8), .busy(busy8), .overrun(ovr8));
   promedio_uart_tx #(.N(16), .CLK_DIV(4)) u16 (
      .clk(clk), .reset(reset), .data_in(d16), .data_valid(dv16), .ovr_clr(clr16),
      .tx(tx16), .busy(busy16), .overrun(ovr16));
   promedio_uart_tx #(.N(12), .CLK_DIV(2)) u12 (
      .clk(clk), .reset(reset), .data_in(d12), .data_valid(dv12), .ovr_clr(clr12),
      .tx(tx12), .busy(busy12), .overrun(ovr12));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic txs(input int idx);
      case (idx)
         0: return tx8;
         1: return tx16;
         default: return tx12;
      endcase
   endfunction

   function automatic logic busys(input int idx);
      case (idx)
         0: return busy8;
         1: return busy16;
         default: return busy12;
      endcase
   endfunction

   // busy run-length recorder
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busys(i) === 1'b1) begin
            run_len[i] = run_len[i] + 1;
         end else if (run_len[i] != 0) begin
            last_run[i] = run_len[i];
            done_cnt[i] = done_cnt[i] + 1;
            run_len[i]  = 0;
         end
      end
   end

   // UART decoder plus scoreboard compare for one instance
   task automatic monitor(input int idx, input int cd);
      logic [7:0] b;
      logic       stp;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (txs(idx) === 1'b0) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
               repeat (cd) @(negedge clk);
               b[i] = txs(idx);
            end
            repeat (cd) @(negedge clk);
            stp = txs(idx);
            if (abort_f[idx]) begin
               abort_f[idx] = 1'b0;
            end else begin
               checks++;
               if (expq[idx].size() == 0) begin
                  errors++;
                  $display("FAIL byte%0d: unexpected byte 0x%02h on tx (nothing expected)", idx, b);
               end else begin
                  e = expq[idx].pop_front();
                  if (b !== e || stp !== 1'b1) begin
                     errors++;
                     $display("FAIL byte%0d: got 0x%02h stop=%b, expected 0x%02h stop=1", idx, b, stp, e);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor(0, 4);
         monitor(1, 4);
         monitor(2, 2);
      join_none
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_hdr(input int idx);
      if (HB == 1) expq[idx].push_back(8'hA5);
   endtask

   // Drive a one-cycle data_valid pulse (called at a negedge, returns at the next one).
   task automatic pulse(input int idx, input logic [15:0] v, input logic clr);
      case (idx)
         0: begin d8 = v[7:0]; dv8 = 1'b1; clr8 = clr; end
         1: begin d16 = v; dv16 = 1'b1; clr16 = clr; end
         default: begin d12 = v[11:0]; dv12 = 1'b1; clr12 = clr; end
      endcase
      @(negedge clk);
      dv8 = 1'b0; dv16 = 1'b0; dv12 = 1'b0;
      clr8 = 1'b0; clr16 = 1'b0; clr12 = 1'b0;
   endtask

   task automatic wait_run(input int idx, input int base, input int exp, input string nm);
      int k;
      k = 0;
      while (done_cnt[idx] == base && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (done_cnt[idx] == base) begin
         errors++;
         $display("FAIL %s: busy never fell within 3000 cycles, expected run of %0d", nm, exp);
      end else if (last_run[idx] != exp) begin
         errors++;
         $display("FAIL %s: busy high %0d cycles, expected %0d", nm, last_run[idx], exp);
      end
   endtask

   initial begin
      int base;
      int k;
      for (int i = 0; i < 3; i++) begin
         abort_f[i] = 1'b0; run_len[i] = 0; last_run[i] = 0; done_cnt[i] = 0;
      end
      reset = 1'b1;
      d8 = '0; dv8 = 1'b0; clr8 = 1'b0;
      d16 = '0; dv16 = 1'b0; clr16 = 1'b0;
      d12 = '0; dv12 = 1'b0; clr12 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx8", 32'(tx8), 32'd1);
      chk("reset_busy8", 32'(busy8), 32'd0);
      chk("reset_ovr8", 32'(ovr8), 32'd0);
      chk("reset_tx16", 32'(tx16), 32'd1);
      chk("reset_tx12", 32'(tx12), 32'd1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // basic frame 0x5A
      base = done_cnt[0];
      push_hdr(0); expq[0].push_back(8'h5A);
      pulse(0, 16'h005A, 1'b0);
      chk("basic_tx_start", 32'(tx8), 32'd0);
      wait_run(0, base, (1 + HB) * 40, "basic_busy");
      chk("basic_ovr", 32'(ovr8), 32'd0);
      repeat (3) @(negedge clk);

      // multi-byte 0x1234
      base = done_cnt[1];
      push_hdr(1); expq[1].push_back(8'h12); expq[1].push_back(8'h34);
      pulse(1, 16'h1234, 1'b0);
      wait_run(1, base, (2 + HB) * 40, "multi_busy");
      repeat (3) @(negedge clk);

      // buffering: 0x11 then 0x22 ten cycles later
      base = done_cnt[0];
      push_hdr(0); expq[0].push_back(8'h11);
      push_hdr(0); expq[0].push_back(8'h22);
      pulse(0, 16'h0011, 1'b0);
      repeat (9) @(negedge clk);
      pulse(0, 16'h0022, 1'b0);
      chk("buffer_ovr", 32'(ovr8), 32'd0);
      wait_run(0, base, 2 * (1 + HB) * 40, "buffer_busy");
      chk("buffer_ovr_end", 32'(ovr8), 32'd0);
      repeat (3) @(negedge clk);

      // overrun: 0x11, 0x22, 0x33 inside one frame; 0x33 is dropped
      base = done_cnt[0];
      push_hdr(0); expq[0].push_back(8'h11);
      push_hdr(0); expq[0].push_back(8'h22);
      pulse(0, 16'h0011, 1'b0);
      repeat (4) @(negedge clk);
      pulse(0, 16'h0022, 1'b0);
      chk("ovr_before", 32'(ovr8), 32'd0);
      repeat (4) @(negedge clk);
      pulse(0, 16'h0033, 1'b0);
      chk("ovr_set", 32'(ovr8), 32'd1);
      wait_run(0, base, 2 * (1 + HB) * 40, "ovr_busy");
      chk("ovr_sticky", 32'(ovr8), 32'd1);
      clr8 = 1'b1;
      @(negedge clk);
      clr8 = 1'b0;
      chk("ovr_clr", 32'(ovr8), 32'd0);
      repeat (2) @(negedge clk);

      // clear coincident with a new drop: set wins
      base = done_cnt[0];
      push_hdr(0); expq[0].push_back(8'h44);
      push_hdr(0); expq[0].push_back(8'h55);
      pulse(0, 16'h0044, 1'b0);
      repeat (4) @(negedge clk);
      pulse(0, 16'h0055, 1'b0);
      repeat (4) @(negedge clk);
      pulse(0, 16'h0066, 1'b1);
      chk("ovr_set_wins", 32'(ovr8), 32'd1);
      wait_run(0, base, 2 * (1 + HB) * 40, "ovr2_busy");
      repeat (3) @(negedge clk);

      // reset during 3rd data bit of 0xF0 (overrun is still 1 going in)
      pulse(0, 16'h00F0, 1'b0);
      repeat ((HB * 40) + 12) @(negedge clk);
      abort_f[0] = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_tx", 32'(tx8), 32'd1);
      chk("rst_mid_busy", 32'(busy8), 32'd0);
      chk("rst_mid_ovr", 32'(ovr8), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      base = done_cnt[0];
      push_hdr(0); expq[0].push_back(8'h0F);
      pulse(0, 16'h000F, 1'b0);
      wait_run(0, base, (1 + HB) * 40, "post_rst_busy");
      repeat (3) @(negedge clk);

      // boundary: N=12, CLK_DIV=2, 0xABC, then a new value exactly as busy falls
      push_hdr(2); expq[2].push_back(8'h0A); expq[2].push_back(8'hBC);
      pulse(2, 16'h0ABC, 1'b0);
      k = 0;
      while (busy12 !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("bnd_busy_fell", 32'(busy12), 32'd0);
      push_hdr(2); expq[2].push_back(8'h01); expq[2].push_back(8'h23);
      pulse(2, 16'h0123, 1'b0);
      chk("bnd_run", 32'(last_run[2]), 32'((2 + HB) * 20));
      chk("bnd_restart_busy", 32'(busy12), 32'd1);
      chk("bnd_restart_tx", 32'(tx12), 32'd0);
      base = done_cnt[2];
      wait_run(2, base, (2 + HB) * 20, "bnd2_busy");
      repeat (5) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         chk($sformatf("queue%0d_drained", i), 32'(expq[i].size()), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
